// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_unit_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sign-extended J-type immediate (JAL offset)
  function automatic logic [XLEN-1:0] jal_imm(input logic [XLEN-1:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and same-cycle push/pop; head_data shows push_data when empty.
// Latency: one cycle push-to-head, zero when empty and pushing and popping together (bypass).
// Backpressure: caller must not push when full unless popping in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          bypass;
  logic          do_write;
  logic          do_read;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  // An entry pushed into an empty FIFO and popped in the same cycle never lands in storage
  assign bypass    = empty & push & pop;
  assign do_write  = push & ~bypass & (~full | pop);
  assign do_read   = pop & ~empty;
  assign head_data = empty ? push_data : mem[rd_ptr];

  // Storage array; contents are don't-care until the pointers cover them
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush drops everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_read)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_write) - CW'(do_read);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, requests words from imem, buffers them, feeds the decoder. Optional EARLY_JUMP_EN.
// Latency: a response in cycle N appears on if_* in cycle N+1 when the buffer is empty and not stalled.
// Backpressure: stall holds if_*; requests are credit-limited so buffered + in-flight never exceed FIFO_DEPTH.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
`ifdef EARLY_JUMP_EN
  output logic        early_jump,
`endif
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard;

  logic          req_fire;
  logic          resp_live;
  logic          resp_drop;
  logic [CW:0]   credits_used;

  logic          redir_any;
  logic [31:0]   redir_target;

  logic          load;
  logic          buf_push;
  logic          buf_pop;
  logic          buf_avail;
  logic          buf_full;
  logic          buf_empty;
  logic [CW-1:0] buf_count;
  fetch_entry_t  buf_in;
  fetch_entry_t  buf_head;

  logic [31:0]   tag_head;
  logic          tag_full;
  logic          tag_empty;
  logic [CW-1:0] tag_count;

  logic          unused_ok;

`ifdef EARLY_JUMP_EN
  logic          ej_pending;
  logic [31:0]   ej_target;
  logic          if_jal;
  logic          head_is_jal;

  // External redirect beats the self-redirect raised by a JAL popped last cycle
  assign redir_any    = redirect_valid | ej_pending;
  assign redir_target = redirect_valid ? {redirect_pc[31:2], 2'b00} : ej_target;
  assign head_is_jal  = (buf_head.instr[6:0] == OPC_JAL);
  assign early_jump   = if_valid & if_jal;
`else
  assign redir_any    = redirect_valid;
  assign redir_target = {redirect_pc[31:2], 2'b00};
`endif

  // Credits count both buffered words and requests whose response is still due
  assign credits_used    = {1'b0, buf_count} + {1'b0, outstanding};
  assign imem_req_valid  = ~rst & ~redir_any & (credits_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr   = pc;
  assign req_fire        = imem_req_valid & imem_req_ready;

  assign resp_drop       = imem_resp_valid & (discard != '0);
  assign resp_live       = imem_resp_valid & (discard == '0);
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

  assign load            = ~stall | ~if_valid;
  assign buf_push        = resp_live;
  assign buf_avail       = ~buf_empty | buf_push;
  assign buf_pop         = ~redir_any & load & buf_avail;
  assign buf_in          = '{pc: tag_head, instr: imem_resp_data};

  assign unused_ok = &{1'b0, tag_full, tag_empty, tag_count, buf_full, redirect_pc[1:0]};

  // Returned words waiting for the decoder
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fetch_entry_t))) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (buf_pop),
    .flush     (redir_any),
    .head_data (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // PC of each live in-flight request, in issue order
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_tag (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp_live),
    .flush     (redir_any),
    .head_data (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  // Fetch PC: redirect wins, otherwise advance on each accepted request
  always_ff @(posedge clk) begin
    if (rst)            pc <= RESET_PC;
    else if (redir_any) pc <= redir_target;
    else if (req_fire)  pc <= pc + 32'd4;
  end

  // In-flight count and number of stale responses still to be thrown away
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redir_any)      discard <= outstanding_nxt;
      else if (resp_drop) discard <= discard - CW'(1);
    end
  end

  // Decoder-facing register: flush on redirect, hold under stall, else take buffer head
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= INST_NOP;
      if_pc    <= 32'h0;
      if_pc4   <= 32'h4;
    end else if (redir_any && (redirect_valid || load)) begin
      if_valid <= 1'b0;
      if_instr <= INST_NOP;
    end else if (buf_pop) begin
      if_valid <= 1'b1;
      if_instr <= buf_head.instr;
      if_pc    <= buf_head.pc;
      if_pc4   <= buf_head.pc + 32'd4;
    end else if (load) begin
      if_valid <= 1'b0;
      if_instr <= INST_NOP;
    end
  end

`ifdef EARLY_JUMP_EN
  // JAL pre-decode: a JAL entering the output register triggers a redirect next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ej_pending <= 1'b0;
      ej_target  <= 32'h0;
      if_jal     <= 1'b0;
    end else begin
      ej_pending <= buf_pop & head_is_jal;
      ej_target  <= buf_head.pc + jal_imm(buf_head.instr);
      if (redir_any && (redirect_valid || load)) if_jal <= 1'b0;
      else if (buf_pop)                           if_jal <= head_is_jal;
      else if (load)                              if_jal <= 1'b0;
    end
  end
`endif

endmodule
